// File: rtl/sprite_line_scheduler.sv
// rtl/sprite_line_scheduler.sv - per-scanline sprite selection and drawer job sequencing
module sprite_line_scheduler #(
  parameter int NUM_SPRITES  = 32,
  parameter int SPRITE_H     = 16,
  parameter int MAX_PER_LINE = 16,
  localparam int IW          = $clog2(NUM_SPRITES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          line_start,
  input  logic [9:0]    line_y,
  output logic [IW-1:0] attr_addr,
  input  logic [31:0]   attr_q,
  output logic          drw_start,
  output logic [9:0]    drw_col_base,
  output logic          drw_flip,
  output logic [7:0]    drw_frame_id,
  output logic [3:0]    drw_row_off,
  input  logic          drw_done,
  output logic          busy,
  output logic          line_done,
  output logic          overflow
);

  localparam int CW = $clog2(MAX_PER_LINE + 1);

  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_SPRITES - 1);
  localparam logic [9:0]    SPRITE_H_W = 10'(SPRITE_H);
  localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_PER_LINE);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]    state;
  logic [9:0]    ly;
  logic [CW-1:0] count;
  logic [9:0]    dy;
  logic          hit;
  logic          cap_reached;
  logic          last_entry;
  logic          unused_attr_bits;

  // Modular row distance lets a sprite near y=1023 wrap onto the top lines.
  assign dy          = ly - attr_q[19:10];
  assign hit         = attr_q[31] && (dy < SPRITE_H_W);
  assign cap_reached = (count >= MAX_CNT);
  assign last_entry  = (attr_addr == LAST_IDX);

  // Reserved attribute bits carry no meaning for the scheduler.
  assign unused_attr_bits = ^attr_q[1:0];

  // Scan FSM: fetch/evaluate each entry, hand hits to the drawer one at a time.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      ly           <= '0;
      count        <= '0;
      attr_addr    <= '0;
      drw_start    <= 1'b0;
      drw_col_base <= '0;
      drw_flip     <= 1'b0;
      drw_frame_id <= '0;
      drw_row_off  <= '0;
      busy         <= 1'b0;
      line_done    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      drw_start <= 1'b0;
      line_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (line_start) begin
            ly        <= line_y;
            attr_addr <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_EVAL;
        end
        S_EVAL: begin
          if (hit && !cap_reached) begin
            drw_col_base <= attr_q[29:20];
            drw_flip     <= attr_q[30];
            drw_frame_id <= attr_q[9:2];
            drw_row_off  <= dy[3:0];
            count        <= count + CW'(1);
            drw_start    <= 1'b1;
            state        <= S_START;
          end else begin
            if (hit) begin
              overflow <= 1'b1;
            end
            if (last_entry) begin
              line_done <= 1'b1;
              state     <= S_FIN;
            end else begin
              attr_addr <= attr_addr + IW'(1);
              state     <= S_FETCH;
            end
          end
        end
        S_START: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (drw_done) begin
            if (last_entry) begin
              line_done <= 1'b1;
              state     <= S_FIN;
            end else begin
              attr_addr <= attr_addr + IW'(1);
              state     <= S_FETCH;
            end
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb/tb_sprite_line_scheduler.sv - scoreboard bench for sprite_line_scheduler
module tb_sprite_line_scheduler;

  localparam int N    = 32;
  localparam int SH   = 16;
  localparam int MAXL = 16;

  typedef struct packed {
    logic [9:0] col;
    logic       flip;
    logic [7:0] frame;
    logic [3:0] row;
  } job_t;

  typedef struct {
    int ovf;
    int lat;
  } line_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic [9:0]  line_y = '0;
  logic [4:0]  attr_addr;
  logic [31:0] attr_q;
  logic        drw_start;
  logic [9:0]  drw_col_base;
  logic        drw_flip;
  logic [7:0]  drw_frame_id;
  logic [3:0]  drw_row_off;
  logic        drw_done;
  logic        busy;
  logic        line_done;
  logic        overflow;

  logic [31:0] mem [N];
  int          drw_dur = 17;
  int          drw_cnt;
  int          cyc = 0;

  job_t  exp_jobs[$];
  line_t exp_lines[$];
  int    checks = 0;
  int    failures = 0;

  int    start_cyc = 0;
  job_t  got_job;
  job_t  exp_job;
  job_t  last_job;
  bit    have_last = 0;
  line_t exp_line;

  sprite_line_scheduler #(.NUM_SPRITES(N), .SPRITE_H(SH), .MAX_PER_LINE(MAXL)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_y(line_y),
    .attr_addr(attr_addr), .attr_q(attr_q), .drw_start(drw_start),
    .drw_col_base(drw_col_base), .drw_flip(drw_flip), .drw_frame_id(drw_frame_id),
    .drw_row_off(drw_row_off), .drw_done(drw_done), .busy(busy),
    .line_done(line_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) attr_q <= mem[attr_addr];

  always @(posedge clk) begin
    if (reset) begin
      drw_done <= 1'b1;
      drw_cnt  <= 0;
    end else if (drw_start) begin
      drw_done <= 1'b0;
      drw_cnt  <= drw_dur;
    end else if (!drw_done) begin
      if (drw_cnt <= 1) drw_done <= 1'b1;
      else drw_cnt <= drw_cnt - 1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_table();
    for (int i = 0; i < N; i++) mem[i] = 32'h0;
  endtask

  function automatic logic [31:0] attr(input bit en, input bit fl, input int x, input int y, input int fr);
    logic [31:0] w;
    w = {en, fl, 10'(x), 10'(y), 8'(fr), 2'b00};
    return w;
  endfunction

  // Reference: walk the table in index order, keep the first MAXL covering sprites.
  task automatic model_line(input logic [9:0] y);
    logic [31:0] w;
    int          hits;
    int          d;
    line_t       l;
    hits  = 0;
    l.ovf = 0;
    for (int i = 0; i < N; i++) begin
      w = mem[i];
      d = (int'(y) - int'(w[19:10]) + 1024) % 1024;
      if (w[31] && d < SH) begin
        if (hits < MAXL) begin
          exp_jobs.push_back({w[29:20], w[30], w[9:2], 4'(d)});
          hits++;
        end else begin
          l.ovf = 1;
        end
      end
    end
    l.lat = (hits == 0) ? 2 * N + 1 : -1;
    exp_lines.push_back(l);
  endtask

  task automatic start_line(input logic [9:0] y, input bit modeled);
    if (modeled) model_line(y);
    line_y     = y;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL %s_timeout: busy=%0b after %0d cycles, expected 0", tag, busy, budget);
    end
  endtask

  task automatic wait_start(input int budget, input string tag);
    int n;
    n = 0;
    while (!drw_start && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!drw_start) begin
      failures++;
      $display("FAIL %s_nostart: drw_start=%0b after %0d cycles, expected 1", tag, drw_start, budget);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic monitor_step();
    if (reset) begin
      have_last = 0;
    end else begin
      if (line_start && !busy) start_cyc = cyc;
      if (drw_start) begin
        got_job = {drw_col_base, drw_flip, drw_frame_id, drw_row_off};
        checks++;
        if (exp_jobs.size() == 0) begin
          failures++;
          $display("FAIL job_unexpected: got %h expected none", got_job);
        end else begin
          exp_job = exp_jobs.pop_front();
          if (got_job !== exp_job) begin
            failures++;
            $display("FAIL job_fields: got col=%0d flip=%0b frame=%0d row=%0d expected col=%0d flip=%0b frame=%0d row=%0d",
                     got_job.col, got_job.flip, got_job.frame, got_job.row,
                     exp_job.col, exp_job.flip, exp_job.frame, exp_job.row);
          end
        end
        last_job  = got_job;
        have_last = 1;
      end else if (busy && !drw_done && have_last) begin
        got_job = {drw_col_base, drw_flip, drw_frame_id, drw_row_off};
        checks++;
        if (got_job !== last_job) begin
          failures++;
          $display("FAIL field_stable: got %h expected %h", got_job, last_job);
        end
      end
      if (line_done) begin
        checks++;
        if (exp_lines.size() == 0) begin
          failures++;
          $display("FAIL line_unexpected: got line_done=1 expected none");
        end else begin
          exp_line = exp_lines.pop_front();
          if (int'(overflow) != exp_line.ovf) begin
            failures++;
            $display("FAIL line_overflow: got %0b expected %0d", overflow, exp_line.ovf);
          end
          if (exp_line.lat >= 0) begin
            checks++;
            if (cyc - start_cyc != exp_line.lat) begin
              failures++;
              $display("FAIL line_latency: got %0d expected %0d", cyc - start_cyc, exp_line.lat);
            end
          end
          checks++;
          if (exp_jobs.size() != 0) begin
            failures++;
            $display("FAIL jobs_missing: got %0d undrawn jobs expected 0", exp_jobs.size());
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    logic [9:0] ly;
    int         tries;
    clear_table();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({attr_addr, drw_start, drw_col_base, drw_flip, drw_frame_id, drw_row_off,
         busy, line_done, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_state: got addr=%0d start=%0b col=%0d busy=%0b done=%0b ovf=%0b expected all 0",
               attr_addr, drw_start, drw_col_base, busy, line_done, overflow);
    end
    reset = 1'b0;
    tick();

    // empty table: fixed latency, no jobs
    start_line(10'd100, 1);
    wait_idle(500, "empty");
    tick();

    // single hit at entry 3
    mem[3] = attr(1, 1, 200, 95, 7);
    start_line(10'd100, 1);
    wait_idle(1000, "single");

    // dy=1023 must be a miss; later line covers both in index order
    clear_table();
    mem[0] = attr(1, 0, 10, 100, 1);
    mem[1] = attr(1, 1, 20, 101, 2);
    start_line(10'd100, 1);
    wait_idle(1000, "skip");
    start_line(10'd115, 1);
    tries = 0;
    while (!line_done && tries < 1000) begin
      tick();
      tries++;
    end
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    check_bit("fin_ignored", busy, 1'b0);

    // wrap: sprite at y=1020 covers line 3
    clear_table();
    mem[9] = attr(1, 0, 700, 1020, 255);
    start_line(10'd3, 1);
    wait_idle(1000, "wrap");

    // overflow: 20 covering sprites, only the first 16 drawn
    clear_table();
    for (int i = 0; i < 20; i++) mem[i] = attr(1, i % 2, 30 * i, 50, i);
    drw_dur = 3;
    start_line(10'd50, 1);
    wait_idle(3000, "ovf");
    repeat (3) tick();
    check_bit("ovf_held", overflow, 1'b1);

    // long drawer: hold in WAIT, ignore a line_start there
    clear_table();
    mem[5] = attr(1, 1, 321, 400, 99);
    mem[6] = attr(1, 0, 322, 405, 98);
    drw_dur = 40;
    start_line(10'd410, 1);
    wait_start(200, "hold");
    repeat (10) tick();
    start_line(10'd600, 0);
    repeat (20) tick();
    check_bit("hold_busy", busy, 1'b1);
    check_bit("hold_done_low", drw_done, 1'b0);
    wait_idle(2000, "hold");

    // reset during WAIT abandons the line, restart begins at index 0
    clear_table();
    mem[0] = attr(1, 0, 5, 60, 3);
    mem[7] = attr(1, 1, 6, 58, 4);
    start_line(10'd62, 1);
    wait_start(200, "rst");
    repeat (3) tick();
    reset = 1'b1;
    exp_jobs.delete();
    exp_lines.delete();
    tick();
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_start", drw_start, 1'b0);
    check_bit("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    tick();
    start_line(10'd62, 1);
    wait_idle(2000, "restart");

    // randomized tables, drawer durations and in-flight line_start noise
    for (int r = 0; r < 16; r++) begin
      ly = 10'($urandom_range(0, 1023));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1)
          mem[i] = attr($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1023),
                        (int'(ly) - int'($urandom_range(0, 24)) + 1024) % 1024, $urandom_range(0, 255));
        else
          mem[i] = $urandom;
      end
      drw_dur = $urandom_range(1, 20);
      start_line(ly, 1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 30)) tick();
        if (busy) start_line(10'($urandom), 0);
      end
      wait_idle(4000, "rand");
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (5) tick();
    checks++;
    if (exp_jobs.size() != 0 || exp_lines.size() != 0) begin
      failures++;
      $display("FAIL drain: got jobs=%0d lines=%0d pending expected 0", exp_jobs.size(), exp_lines.size());
    end
  endtask

  initial begin
    fork
      begin
        forever begin
          @(negedge clk);
          monitor_step();
        end
      end
      stimulus();
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline controller for the 16x16 sprite drawer.
- On each line_start it scans the sprite attribute table in index order and selects the sprites that cover the requested scanline.
- For each selected sprite it issues one drawer job (col_base, flip, frame_id, row_off) and waits for the drawer's done before moving on.
- It sits between the line-timing logic / attribute RAM and the sprite drawer feeding the line buffer.

Parameters:
- NUM_SPRITES, 32, attribute table entries (power of 2, ≥2); index width IW = log2(NUM_SPRITES).
- SPRITE_H, 16, sprite height in rows (≤16, fits row_off 4 bits).
- MAX_PER_LINE, 16, maximum drawer jobs per scanline (≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- line_start  in  1  one-cycle pulse: begin scheduling line line_y
- line_y  in  10  target scanline, sampled only when line_start is accepted
- attr_addr  out  IW  attribute RAM read address (RAM is synchronous, 1-cycle read latency)
- attr_q  in  32  attribute word: [31] enable, [30] flip, [29:20] x, [19:10] y, [9:2] frame_id, [1:0] reserved
- drw_start  out  1  one-cycle start pulse to the drawer
- drw_col_base  out  10  sprite x
- drw_flip  out  1  horizontal flip
- drw_frame_id  out  8  frame index
- drw_row_off  out  4  row within the sprite
- drw_done  in  1  drawer idle/finished (1 after reset; drops the cycle after start is sampled)
- busy  out  1  line scheduling in progress
- line_done  out  1  one-cycle pulse when the line is complete
- overflow  out  1  more than MAX_PER_LINE hits on the current/last line

Behaviour:
Reset:
- State IDLE; all outputs 0 (attr_addr, drw_* fields, drw_start, busy, line_done, overflow); hit counter 0.
- Reset mid-line abandons the scan immediately; drw_start is never asserted in the reset cycle.

States: IDLE, FETCH, EVAL, START, WAIT, FIN.
- IDLE: on line_start:
  - latch ly ← line_y; attr_addr ← 0; count ← 0; overflow ← 0; busy ← 1; go to FETCH.
- FETCH: one cycle for RAM latency; go to EVAL.
- EVAL: compute dy = ly − attr_q.y, 10-bit unsigned with wrap. hit = attr_q[31] && (dy < SPRITE_H).
  - hit and count < MAX_PER_LINE:
    - register drw_col_base = x, drw_flip, drw_frame_id, drw_row_off = dy[3:0];
    - count++; go to START.
  - hit and count == MAX_PER_LINE: overflow ← 1; treat as a miss.
  - miss: ADVANCE.
- START: drw_start = 1 for exactly this cycle; go to WAIT.
- WAIT: hold; when drw_done = 1, ADVANCE.
  - drw_done is already 0 on WAIT entry because of the drawer's 1-cycle response.
- ADVANCE: if attr_addr == NUM_SPRITES−1 go to FIN; else attr_addr++ and go to FETCH.
- FIN: line_done = 1 for one cycle; busy ← 0; go to IDLE.

Stability and ordering:
- drw_col_base, drw_flip, drw_frame_id and drw_row_off change only in EVAL on a hit and stay stable through WAIT; the drawer uses flip/col_base combinationally while drawing.
- x beyond 639 is passed through unchanged; the drawer clips.
- Wrap: a sprite with y near 1023 covers lines 0.. via modular dy. This is intended.
- Draw order is ascending index, so the higher index wins on overlap.

Cost and boundaries:
- Miss costs 2 cycles (FETCH + EVAL).
- Hit costs 3 cycles plus drawer time (START + WAIT; the drawer needs about 17 cycles).
- Empty table: line_done exactly 2·NUM_SPRITES + 1 cycles after line_start acceptance.
- line_start while busy: ignored (no relatch, no restart).
- line_start in the FIN cycle: ignored; accepted only in IDLE.
- overflow stays valid until the next accepted line_start.

Test Plan:
- All entries disabled, line_start with line_y=100 → no drw_start; line_done exactly 65 cycles later; overflow=0.
- Entry 3 = {en=1, flip=1, x=200, y=95, frame=7}, line_y=100 → one drw_start with col_base=200, flip=1, frame_id=7, row_off=5; line_done after the drawer's done.
- Entries 0 and 1 with y=100 and y=101, line_y=100 → only entry 0 is drawn; entry 1 (dy=1023) is skipped. Then line_y=115 → both drawn, row_off 15 and 14, in index order.
- 20 enabled sprites with y=50, line_y=50 → exactly 16 drw_start pulses (indices 0–15); overflow=1 at line_done.
- Drawer model holds done low for 40 cycles → scheduler stays in WAIT and drw_* fields stay constant; a line_start injected during WAIT is ignored.
- Assert reset during WAIT → next cycle busy=0, drw_start=0, overflow=0; a new line_start restarts from index 0.
